// File: rtl/mips_fetch_unit_pkg.sv
// ============================================================================
// Module : mips_fetch_unit_pkg
// Brief  : Shared types and constants for the MIPS fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_fetch_unit_pkg;

  typedef enum logic [5:0] {
    Rtype = 6'h00,
    JUMP  = 6'h02,
    BEQ   = 6'h04,
    ADDI  = 6'h08,
    SUBI  = 6'h09,
    LW    = 6'h23,
    SW    = 6'h2B
  } op_code;

  typedef enum logic [5:0] {
    SLL_f = 6'h00,
    ADD_f = 6'h20,
    SUB_f = 6'h22,
    AND_f = 6'h24,
    OR_f  = 6'h25,
    SLT_f = 6'h2A
  } func_code;

  typedef logic [4:0]  RegInBits;
  typedef logic [4:0]  saBits;
  typedef logic [15:0] ImmBits;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] c_HALT_WORD = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/mips_fetch_unit_if.sv
// ============================================================================
// Module : mips_fetch_unit_if
// Brief  : Loader/core-facing bus of the fetch stage (master = host side).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_fetch_unit_if
  import mips_fetch_unit_pkg::*;
#(
  parameter int N        = 32,
  parameter int Pb       = 32,
  parameter int IM_DEPTH = 64
) ();

  logic                        start;
  logic                        stall;
  logic [Pb-1:0]               nxt_pc;
  logic                        prog_we;
  logic [$clog2(IM_DEPTH)-1:0] prog_addr;
  logic [N-1:0]                prog_data;

  logic [Pb-1:0]               PC;
  op_code                      op;
  RegInBits                    rs;
  RegInBits                    rt;
  RegInBits                    rd;
  saBits                       sa;
  func_code                    func;
  ImmBits                      Imm;
  logic                        instr_valid;
  logic                        halted;
  logic                        fault;
  logic [Pb-1:0]               retired;

  modport master (
    output start, stall, nxt_pc, prog_we, prog_addr, prog_data,
    input  PC, op, rs, rt, rd, sa, func, Imm, instr_valid, halted, fault, retired
  );

  modport slave (
    input  start, stall, nxt_pc, prog_we, prog_addr, prog_data,
    output PC, op, rs, rt, rd, sa, func, Imm, instr_valid, halted, fault, retired
  );

endinterface

`default_nettype wire

// File: rtl/mips_fetch_unit_imem.sv
// ============================================================================
// Module : mips_imem
// Brief  : Word-addressed instruction memory, one write port, async read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_imem #(
  parameter int N        = 32,
  parameter int IM_DEPTH = 64
) (
  input  wire logic                        clk,
  input  wire logic                        we,
  input  wire logic [$clog2(IM_DEPTH)-1:0] waddr,
  input  wire logic [N-1:0]                wdata,
  input  wire logic [$clog2(IM_DEPTH)-1:0] raddr,
  output logic      [N-1:0]                rdata
);

  logic [N-1:0] r_mem [IM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/mips_fetch_unit.sv
// ============================================================================
// Module : mips_fetch_unit
// Brief  : Instruction fetch stage: imem, PC register, run/halt FSM, retire count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter int          N         = 32,
  parameter int          Pb        = 32,
  parameter int          IM_DEPTH  = 64,
  parameter int          RESET_PC  = 0,
  parameter logic [31:0] HALT_WORD = c_HALT_WORD
) (
  input wire logic       clk,
  input wire logic       rst,
  mips_fetch_unit_if.slave bus
);

  localparam int c_AW = $clog2(IM_DEPTH);

  fetch_state_t  r_state, w_state_nxt;
  logic [Pb-1:0] r_pc, w_pc_nxt;
  logic [Pb-1:0] r_retired, w_retired_nxt;
  logic          r_fault, w_fault_nxt;
  logic [N-1:0]  w_instr;
  logic          w_run, w_is_halt, w_oob, w_imem_we;

  // Loader writes only land while idle; reset suppresses them outright.
  assign w_imem_we = bus.prog_we && (r_state == IDLE) && !rst;

  mips_imem #(
    .N        (N),
    .IM_DEPTH (IM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (w_imem_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (r_pc[c_AW-1:0]),
    .rdata (w_instr)
  );

  assign w_run     = (r_state == RUN);
  assign w_is_halt = (w_instr == HALT_WORD);
  assign w_oob     = (bus.nxt_pc >= Pb'(IM_DEPTH));

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_retired_nxt = r_retired;
    w_fault_nxt   = r_fault;
    case (r_state)
      IDLE, HALT: begin
        if (bus.start) begin
          w_state_nxt   = RUN;
          w_pc_nxt      = Pb'(RESET_PC);
          w_retired_nxt = '0;
          w_fault_nxt   = 1'b0;
        end
      end
      RUN: begin
        // Stall masks both the halt word and the range check.
        if (!bus.stall) begin
          if (w_is_halt) begin
            w_state_nxt = HALT;
          end else if (w_oob) begin
            w_state_nxt   = HALT;
            w_fault_nxt   = 1'b1;
            w_retired_nxt = r_retired + 1'b1;
          end else begin
            w_pc_nxt      = bus.nxt_pc;
            w_retired_nxt = r_retired + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= Pb'(RESET_PC);
      r_retired <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_retired <= w_retired_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign bus.PC          = r_pc;
  assign bus.retired     = r_retired;
  assign bus.fault       = r_fault;
  assign bus.instr_valid = w_run;
  assign bus.halted      = (r_state == HALT);

  assign bus.op   = w_run ? op_code'(w_instr[31:26])   : Rtype;
  assign bus.rs   = w_run ? w_instr[25:21]             : '0;
  assign bus.rt   = w_run ? w_instr[20:16]             : '0;
  assign bus.rd   = w_run ? w_instr[15:11]             : '0;
  assign bus.sa   = w_run ? w_instr[10:6]              : '0;
  assign bus.func = w_run ? func_code'(w_instr[5:0])   : SLL_f;
  assign bus.Imm  = w_run ? w_instr[15:0]              : '0;

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
// ============================================================================
// Module : tb_mips_fetch_unit
// Brief  : Directed self-checking bench for mips_fetch_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_fetch_unit;
  import mips_fetch_unit_pkg::*;

  localparam logic [31:0] c_ADD  = 32'h0022_1820; // add  r3,r1,r2
  localparam logic [31:0] c_ADDI = 32'h2021_0005; // addi r1,r1,5
  localparam logic [31:0] c_SUBI = 32'h2442_0003; // subi r2,r2,3
  localparam logic [31:0] c_J9   = 32'h0800_0009; // j 9
  localparam logic [31:0] c_HW   = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mips_fetch_unit_if #(.N(32), .Pb(32), .IM_DEPTH(64)) bus ();

  mips_fetch_unit #(
    .N(32), .Pb(32), .IM_DEPTH(64), .RESET_PC(0), .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] addr, input logic [31:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.nxt_pc = '0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    tick();
    chk("rst_pc", bus.PC, 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_op", 32'(bus.op), 0);
    chk("rst_imm", 32'(bus.Imm), 0);
    rst = 1'b0;

    // Load path: write and start in the same cycle
    bus.prog_we = 1'b1; bus.prog_addr = 6'd0; bus.prog_data = c_ADD; bus.start = 1'b1;
    tick();
    bus.prog_we = 1'b0; bus.start = 1'b0;
    chk("add_valid", 32'(bus.instr_valid), 1);
    chk("add_pc", bus.PC, 0);
    chk("add_op", 32'(bus.op), 32'h00);
    chk("add_func", 32'(bus.func), 32'h20);
    chk("add_rs", 32'(bus.rs), 1);
    chk("add_rt", 32'(bus.rt), 2);
    chk("add_rd", 32'(bus.rd), 3);
    chk("add_imm", 32'(bus.Imm), 32'h1820);
    bus.nxt_pc = 1;
    tick();
    chk("add_pc1", bus.PC, 1);
    chk("add_ret1", bus.retired, 1);

    // Halt program; writes while running are ignored
    rst = 1'b1; tick(); rst = 1'b0;
    load(6'd0, c_ADDI); load(6'd1, c_SUBI); load(6'd2, c_HW);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("h_pc0", bus.PC, 0);
    chk("h_op0", 32'(bus.op), 32'h08);
    chk("h_imm0", 32'(bus.Imm), 5);
    bus.nxt_pc = 1; tick();
    chk("h_pc1", bus.PC, 1);
    chk("h_op1", 32'(bus.op), 32'h09);
    bus.nxt_pc = 2; tick();
    chk("h_pc2", bus.PC, 2);
    chk("h_valid2", 32'(bus.instr_valid), 1);
    bus.nxt_pc = 3; tick();
    chk("h_halted", 32'(bus.halted), 1);
    chk("h_pc_hold", bus.PC, 2);
    chk("h_ret", bus.retired, 2);
    chk("h_valid0", 32'(bus.instr_valid), 0);
    chk("h_op_zero", 32'(bus.op), 0);
    chk("h_rt_zero", 32'(bus.rt), 0);
    chk("h_fault", 32'(bus.fault), 0);

    // Stall from a restart out of HALT; prog_we in HALT ignored
    load(6'd0, 32'h1234_5678);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("s_pc0", bus.PC, 0);
    chk("s_ret0", bus.retired, 0);
    chk("s_halt_we_ignored", 32'(bus.op), 32'h08);
    bus.nxt_pc = 1; tick();
    chk("s_pc1", bus.PC, 1);
    bus.stall = 1'b1; bus.nxt_pc = 2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_pc_hold", bus.PC, 1);
      chk("s_ret_hold", bus.retired, 1);
      chk("s_op_driven", 32'(bus.op), 32'h09);
    end
    bus.prog_we = 1'b1; bus.prog_addr = 6'd1; bus.prog_data = c_ADD; tick(); bus.prog_we = 1'b0;
    chk("s_run_we_ignored", 32'(bus.op), 32'h09);
    bus.stall = 1'b0; tick();
    chk("s_pc2", bus.PC, 2);
    chk("s_ret2", bus.retired, 2);
    bus.stall = 1'b1; tick();
    chk("s_stalled_halt", 32'(bus.halted), 0);
    bus.stall = 1'b0; tick();
    chk("s_halt_after", 32'(bus.halted), 1);

    // Jump then out-of-range fault
    rst = 1'b1; tick(); rst = 1'b0;
    load(6'd0, c_J9); load(6'd9, c_ADD); load(6'd63, c_HW);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("j_op", 32'(bus.op), 32'h02);
    bus.nxt_pc = 9; tick();
    chk("j_pc9", bus.PC, 9);
    chk("j_func", 32'(bus.func), 32'h20);
    bus.nxt_pc = 64; tick();
    chk("f_halted", 32'(bus.halted), 1);
    chk("f_fault", 32'(bus.fault), 1);
    chk("f_pc", bus.PC, 9);
    chk("f_ret", bus.retired, 2);

    // Restart from faulted HALT clears fault; 63 is legal, halt word beats range check
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("r_pc0", bus.PC, 0);
    chk("r_fault_clr", 32'(bus.fault), 0);
    chk("r_ret0", bus.retired, 0);
    bus.nxt_pc = 63; tick();
    chk("b_pc63", bus.PC, 63);
    chk("b_nofault", 32'(bus.fault), 0);
    bus.nxt_pc = 64; tick();
    chk("b_halted", 32'(bus.halted), 1);
    chk("b_hw_prec", 32'(bus.fault), 0);
    chk("b_ret", bus.retired, 1);

    // Mid-run reset at PC=5; imem preserved
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.nxt_pc = 5; tick();
    chk("m_pc5", bus.PC, 5);
    rst = 1'b1; bus.start = 1'b1; tick(); rst = 1'b0; bus.start = 1'b0;
    chk("m_pc0", bus.PC, 0);
    chk("m_idle", 32'(bus.instr_valid), 0);
    chk("m_ret0", bus.retired, 0);
    chk("m_fault0", 32'(bus.fault), 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("m_preserved_op", 32'(bus.op), 32'h02);
    chk("m_preserved_imm", 32'(bus.Imm), 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
